// File: rtl/mips_control_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset datapath: fetches into an
// internal IR and steps FETCH/DECODE/EXEC/MEM/WB/BR, halting on illegal ops or overflow.
module mips_control_fsm #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        F_zero,
    input  logic        F_overflow,
    output logic        instr_req,
    output logic [4:0]  read_reg_1,
    output logic [4:0]  read_reg_2,
    output logic [4:0]  write_reg,
    output logic        write,
    output logic        wb_sel,
    output logic        alu_src,
    output logic [31:0] alu_op,
    output logic [31:0] imm_ext,
    output logic [25:0] jump_addr,
    output logic        pc_inc,
    output logic        pc_ld,
    output logic        pc_src,
    output logic        dmu_wen,
    output logic        exc,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BR     = 3'd5,
        S_HALT   = 3'd7
    } state_t;

    state_t      cur_state;
    state_t      nxt_state;
    logic [31:0] ir;
    logic [15:0] cnt;
    logic        zero_q;
    logic        exc_q;
    logic        run;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        is_r;
    logic        r_add;
    logic        r_sub;
    logic        r_and;
    logic        r_or;
    logic        r_slt;
    logic        is_addi;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        is_j;
    logic        legal;
    logic        ovf_chk;
    logic        last_exec;
    logic        last_mem;
    logic [2:0]  op_code;

    assign opcode  = ir[31:26];
    assign funct   = ir[5:0];
    assign is_r    = (opcode == 6'h00);
    assign r_add   = is_r && (funct == 6'h20);
    assign r_sub   = is_r && (funct == 6'h22);
    assign r_and   = is_r && (funct == 6'h24);
    assign r_or    = is_r && (funct == 6'h25);
    assign r_slt   = is_r && (funct == 6'h2A);
    assign is_addi = (opcode == 6'h08);
    assign is_lw   = (opcode == 6'h23);
    assign is_sw   = (opcode == 6'h2B);
    assign is_beq  = (opcode == 6'h04);
    assign is_j    = (opcode == 6'h02);
    assign legal   = r_add | r_sub | r_and | r_or | r_slt
                   | is_addi | is_lw | is_sw | is_beq | is_j;
    assign ovf_chk = r_add | r_sub | is_addi;

    assign last_exec = (cnt == 16'(ALU_LAT - 1));
    assign last_mem  = (cnt == 16'(MEM_LAT - 1));

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // run delays instr_req by one edge after clr falls; fetch only accepts while requesting
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ir     <= '0;
            cnt    <= '0;
            zero_q <= 1'b0;
            exc_q  <= 1'b0;
            run    <= 1'b0;
        end else begin
            run <= 1'b1;
            if (cur_state == S_FETCH && run && instr_valid) begin
                ir <= instr;
            end
            if (nxt_state == S_HALT) begin
                exc_q <= 1'b1;
            end
            if (nxt_state == cur_state && (cur_state == S_EXEC || cur_state == S_MEM)) begin
                cnt <= cnt + 16'd1;
            end else begin
                cnt <= '0;
            end
            if (cur_state == S_EXEC && last_exec && is_beq) begin
                zero_q <= F_zero;
            end
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_FETCH: begin
                if (run && instr_valid) nxt_state = S_DECODE;
            end
            S_DECODE: begin
                if (!legal)     nxt_state = S_HALT;
                else if (is_j)  nxt_state = S_FETCH;
                else            nxt_state = S_EXEC;
            end
            S_EXEC: begin
                if (last_exec) begin
                    if (ovf_chk && F_overflow) nxt_state = S_HALT;
                    else if (is_beq)           nxt_state = S_BR;
                    else if (is_lw || is_sw)   nxt_state = S_MEM;
                    else                       nxt_state = S_WB;
                end
            end
            S_MEM: begin
                if (is_sw)         nxt_state = S_FETCH;
                else if (last_mem) nxt_state = S_WB;
            end
            S_WB:    nxt_state = S_FETCH;
            S_BR:    nxt_state = S_FETCH;
            S_HALT:  nxt_state = S_HALT;
            default: nxt_state = S_HALT;
        endcase
    end

    always_comb begin
        instr_req = 1'b0;
        write     = 1'b0;
        pc_inc    = 1'b0;
        pc_ld     = 1'b0;
        pc_src    = 1'b0;
        dmu_wen   = 1'b0;
        case (cur_state)
            S_FETCH: instr_req = run;
            S_DECODE: begin
                if (is_j) begin
                    pc_ld  = 1'b1;
                    pc_src = 1'b1;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    dmu_wen = 1'b1;
                    pc_inc  = 1'b1;
                end
            end
            S_WB: begin
                write  = (write_reg != 5'd0);
                pc_inc = 1'b1;
            end
            S_BR: begin
                if (zero_q) pc_ld  = 1'b1;
                else        pc_inc = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        op_code = 3'd0;
        if (is_beq || r_sub)  op_code = 3'd1;
        else if (r_and)       op_code = 3'd2;
        else if (r_or)        op_code = 3'd3;
        else if (r_slt)       op_code = 3'd4;
    end

    assign alu_op     = {29'd0, op_code};
    assign alu_src    = is_addi | is_lw | is_sw;
    assign wb_sel     = is_lw;
    assign read_reg_1 = ir[25:21];
    assign read_reg_2 = ir[20:16];
    assign write_reg  = is_r ? ir[15:11] : ir[20:16];
    assign imm_ext    = {{16{ir[15]}}, ir[15:0]};
    assign jump_addr  = ir[25:0];
    assign exc        = exc_q;
    assign state      = cur_state;

    pc_update_exclusive: assert property (@(posedge clk) disable iff (clr)
        !(pc_inc && pc_ld));
    halt_quiet: assert property (@(posedge clk) disable iff (clr)
        (cur_state == S_HALT) |-> !(write || dmu_wen || pc_inc || pc_ld || instr_req));

endmodule

// File: tb/tb_mips_control_fsm.sv
// Self-checking bench for mips_control_fsm: per-instruction vector table with a
// scoreboard queue, plus hand sequences for reset, halt and mid-instruction abort.
module tb_mips_control_fsm;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        F_zero = 1'b0;
    logic        F_overflow = 1'b0;
    logic        instr_req;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic [4:0]  write_reg;
    logic        write;
    logic        wb_sel;
    logic        alu_src;
    logic [31:0] alu_op;
    logic [31:0] imm_ext;
    logic [25:0] jump_addr;
    logic        pc_inc;
    logic        pc_ld;
    logic        pc_src;
    logic        dmu_wen;
    logic        exc;
    logic [2:0]  state;

    mips_control_fsm #(.ALU_LAT(1), .MEM_LAT(1)) dut (
        .clk(clk), .clr(clr), .instr(instr), .instr_valid(instr_valid),
        .F_zero(F_zero), .F_overflow(F_overflow), .instr_req(instr_req),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2), .write_reg(write_reg),
        .write(write), .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op),
        .imm_ext(imm_ext), .jump_addr(jump_addr), .pc_inc(pc_inc), .pc_ld(pc_ld),
        .pc_src(pc_src), .dmu_wen(dmu_wen), .exc(exc), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zero;
        logic        ovf;
        logic [17:0] trace;
        int          cycles;
        int          writes;
        logic [4:0]  wreg;
        logic        wb_sel;
        int          incs;
        int          lds;
        logic        pc_src;
        int          wens;
        logic [31:0] alu_op;
        logic        alu_src;
        logic        exc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] ins, input logic z,
                                input logic o, input logic [17:0] tr, input int cyc,
                                input int wr, input logic [4:0] wreg, input logic wbs,
                                input int inc, input int ld, input logic psrc, input int wen,
                                input logic [31:0] aop, input logic asrc, input logic ex);
        vec_t v;
        v.name = name; v.instr = ins; v.zero = z; v.ovf = o; v.trace = tr;
        v.cycles = cyc; v.writes = wr; v.wreg = wreg; v.wb_sel = wbs; v.incs = inc;
        v.lds = ld; v.pc_src = psrc; v.wens = wen; v.alu_op = aop; v.alu_src = asrc;
        v.exc = ex;
        return v;
    endfunction

    task automatic do_reset();
        clr = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    // Entered at a negedge with the DUT in FETCH and requesting.
    task automatic run_vec(input vec_t v);
        vec_t        e;
        logic [17:0] trace = '0;
        int          cyc = 1;
        int          guard = 0;
        int          writes = 0, incs = 0, lds = 0, wens = 0, both = 0;
        logic [4:0]  o_wreg = '0, o_rr1 = '0, o_rr2 = '0;
        logic        o_wbsel = 1'b0, o_psrc = 1'b0, o_asrc = 1'b0;
        logic [31:0] o_aop = '0, o_imm = '0;
        logic [25:0] o_jaddr = '0;
        sb.push_back(v);
        instr = v.instr; instr_valid = 1'b1; F_zero = v.zero; F_overflow = v.ovf;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 32'hDEADBEEF;
        while (state != 3'd0 && state != 3'd7 && guard < 50) begin
            trace = {trace[14:0], state};
            cyc++;
            if (state == 3'd1) begin
                o_rr1 = read_reg_1; o_rr2 = read_reg_2; o_imm = imm_ext; o_jaddr = jump_addr;
            end
            if (state == 3'd2) begin o_aop = alu_op; o_asrc = alu_src; end
            if (state == 3'd4) o_wbsel = wb_sel;
            if (write) begin writes++; o_wreg = write_reg; end
            if (pc_inc) incs++;
            if (pc_ld) begin lds++; o_psrc = pc_src; end
            if (dmu_wen) wens++;
            if (pc_inc && pc_ld) both++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) chk({v.name, " timeout"}, 32'(guard), 32'd0);
        trace = {trace[14:0], state};
        e = sb.pop_front();
        chk({e.name, " trace"},   32'(trace),   32'(e.trace));
        chk({e.name, " cycles"},  32'(cyc),     32'(e.cycles));
        chk({e.name, " writes"},  32'(writes),  32'(e.writes));
        chk({e.name, " wreg"},    32'(o_wreg),  32'(e.wreg));
        chk({e.name, " wb_sel"},  32'(o_wbsel), 32'(e.wb_sel));
        chk({e.name, " pc_inc"},  32'(incs),    32'(e.incs));
        chk({e.name, " pc_ld"},   32'(lds),     32'(e.lds));
        chk({e.name, " pc_src"},  32'(o_psrc),  32'(e.pc_src));
        chk({e.name, " dmu_wen"}, 32'(wens),    32'(e.wens));
        chk({e.name, " both"},    32'(both),    32'd0);
        chk({e.name, " alu_op"},  o_aop,        e.alu_op);
        chk({e.name, " alu_src"}, 32'(o_asrc),  32'(e.alu_src));
        chk({e.name, " imm"},     o_imm,        {{16{e.instr[15]}}, e.instr[15:0]});
        chk({e.name, " jaddr"},   32'(o_jaddr), 32'(e.instr[25:0]));
        chk({e.name, " rr1"},     32'(o_rr1),   32'(e.instr[25:21]));
        chk({e.name, " rr2"},     32'(o_rr2),   32'(e.instr[20:16]));
        chk({e.name, " exc"},     32'(exc),     32'(e.exc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic strobes;
        //       name        instr          z  o  trace                                 cyc wr wreg wbs inc ld psrc wen aop asrc exc
        vecs.push_back(mk("add",      32'h012A4020, 0, 0, 18'({3'd1,3'd2,3'd4,3'd0}),      4, 1, 5'd8, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw",       32'h8D280004, 0, 0, 18'({3'd1,3'd2,3'd3,3'd4,3'd0}), 5, 1, 5'd8, 1, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("sw",       32'hAD280004, 0, 0, 18'({3'd1,3'd2,3'd3,3'd0}),      4, 0, 5'd0, 0, 1, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk("beq_t",    32'h1128FFFC, 1, 0, 18'({3'd1,3'd2,3'd5,3'd0}),      4, 0, 5'd0, 0, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk("beq_nt",   32'h1128FFFC, 0, 1, 18'({3'd1,3'd2,3'd5,3'd0}),      4, 0, 5'd0, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("j",        32'h08000010, 0, 0, 18'({3'd1,3'd0}),                2, 0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("sub",      32'h00221822, 0, 0, 18'({3'd1,3'd2,3'd4,3'd0}),      4, 1, 5'd3, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("and_ovf",  32'h00222024, 0, 1, 18'({3'd1,3'd2,3'd4,3'd0}),      4, 1, 5'd4, 0, 1, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk("or",       32'h00222825, 0, 0, 18'({3'd1,3'd2,3'd4,3'd0}),      4, 1, 5'd5, 0, 1, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk("slt",      32'h0022302A, 0, 0, 18'({3'd1,3'd2,3'd4,3'd0}),      4, 1, 5'd6, 0, 1, 0, 0, 0, 4, 0, 0));
        vecs.push_back(mk("addi_r0",  32'h20200005, 0, 0, 18'({3'd1,3'd2,3'd4,3'd0}),      4, 0, 5'd0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("addi_neg", 32'h2027FFFF, 0, 0, 18'({3'd1,3'd2,3'd4,3'd0}),      4, 1, 5'd7, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("lw_ovf",   32'h8D280004, 0, 1, 18'({3'd1,3'd2,3'd3,3'd4,3'd0}), 5, 1, 5'd8, 1, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("bad_fn",   32'h00222021, 0, 0, 18'({3'd1,3'd7}),                2, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("add_ovf",  32'h012A4020, 0, 1, 18'({3'd1,3'd2,3'd7}),           3, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("addi_ovf", 32'h2027FFFF, 0, 1, 18'({3'd1,3'd2,3'd7}),           3, 0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("sub_ovf",  32'h00221822, 0, 1, 18'({3'd1,3'd2,3'd7}),           3, 0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 1));

        // Reset state, with a valid instruction already presented
        clr = 1'b1; instr_valid = 1'b1; instr = 32'h012A4020;
        repeat (2) @(negedge clk);
        strobes = write | pc_inc | pc_ld | dmu_wen;
        chk("rst state",   32'(state),     32'd0);
        chk("rst req",     32'(instr_req), 32'd0);
        chk("rst exc",     32'(exc),       32'd0);
        chk("rst strobes", 32'(strobes),   32'd0);
        clr = 1'b0;
        #1 chk("req before edge", 32'(instr_req), 32'd0);
        @(negedge clk);
        chk("req after edge", 32'(instr_req), 32'd1);
        chk("state after rst", 32'(state), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (state == 3'd7) do_reset();
            run_vec(vecs[i]);
        end

        // Illegal opcode: sticky HALT ignores fetch attempts
        do_reset();
        run_vec(mk("illegal", 32'hFC000000, 0, 0, 18'({3'd1,3'd7}), 2, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1));
        instr = 32'h012A4020;
        for (int k = 0; k < 4; k++) begin
            instr_valid = k[0];
            @(negedge clk);
            strobes = write | pc_inc | pc_ld | dmu_wen | instr_req;
            chk("halt state",   32'(state),   32'd7);
            chk("halt exc",     32'(exc),     32'd1);
            chk("halt strobes", 32'(strobes), 32'd0);
        end

        // Starved fetch
        do_reset();
        instr_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle state", 32'(state),     32'd0);
            chk("idle req",   32'(instr_req), 32'd1);
        end

        // clr mid-EXEC aborts the add before WB
        instr = 32'h012A4020; instr_valid = 1'b1; F_overflow = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("pre-abort state", 32'(state), 32'd2);
        #2 clr = 1'b1;
        #1;
        strobes = write | pc_inc | pc_ld | dmu_wen;
        chk("abort state",   32'(state),     32'd0);
        chk("abort req",     32'(instr_req), 32'd0);
        chk("abort strobes", 32'(strobes),   32'd0);
        chk("abort exc",     32'(exc),       32'd0);
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            strobes = write | pc_inc | pc_ld | dmu_wen;
            chk("post-abort strobes", 32'(strobes), 32'd0);
            chk("post-abort state",   32'(state),   32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
